sdr_16_port_arbiter: RTL and testbench



---
 rtl/sdr_16_pkg.sv | 19 +
 rtl/sdr_16_port_arbiter_if.sv | 25 ++
 rtl/sdr_16_rr_pick.sv | 36 +++
 rtl/sdr_16_port_arbiter.sv | 96 +++++++++
 tb/tb_sdr_16_port_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/sdr_16_pkg.sv
// sdr_16_pkg: shared SDR-16 controller constants and arbiter state encoding
//   SDR_DATA_W / SDR_ADR_W   - SDRAM data and address widths
//   ARB_*                    - port arbiter defaults (ports, refresh spacing, urgency, saturation)
//   arb_state_t              - arbiter FSM encoding
package sdr_16_pkg;
    localparam int SDR_DATA_W         = 16;
    localparam int SDR_ADR_W          = 24;
    localparam int ARB_NPORTS         = 4;
    localparam int ARB_REFRESH_CYCLES = 780;
    localparam int ARB_URGENT_LEVEL   = 4;
    localparam int ARB_MAX_PENDING    = 8;
    typedef enum logic [2:0] {
        ARB_WAIT_INIT,
        ARB_IDLE,
        ARB_GRANT,
        ARB_BUSY,
        ARB_RFR
    } arb_state_t;
endpackage

// File: rtl/sdr_16_port_arbiter_if.sv
// sdr_16_port_arbiter_if: requester/controller <-> arbiter signal bundle
//   req, state_idle, cmd_aref                       - driven by requesters and controller (master)
//   gnt, port_sel, refresh_req, busy, refresh_overflow - driven by the arbiter (slave)
interface sdr_16_port_arbiter_if
    import sdr_16_pkg::*;
#(
    parameter int NPORTS = ARB_NPORTS
);
    logic [NPORTS-1:0]         req;
    logic                      state_idle;
    logic                      cmd_aref;
    logic [NPORTS-1:0]         gnt;
    logic [$clog2(NPORTS)-1:0] port_sel;
    logic                      refresh_req;
    logic                      busy;
    logic                      refresh_overflow;
    modport master (
        output req, state_idle, cmd_aref,
        input  gnt, port_sel, refresh_req, busy, refresh_overflow
    );
    modport slave (
        input  req, state_idle, cmd_aref,
        output gnt, port_sel, refresh_req, busy, refresh_overflow
    );
endinterface

// File: rtl/sdr_16_rr_pick.sv
// sdr_16_rr_pick: combinational round-robin priority encoder
//   req   - request vector
//   ptr   - highest-priority port this round
//   oh    - one-hot winner, zero when no request
//   idx   - encoded winner
//   valid - any request present
module sdr_16_rr_pick
    import sdr_16_pkg::*;
#(
    parameter int NPORTS = ARB_NPORTS
) (
    input  logic [NPORTS-1:0]         req,
    input  logic [$clog2(NPORTS)-1:0] ptr,
    output logic [NPORTS-1:0]         oh,
    output logic [$clog2(NPORTS)-1:0] idx,
    output logic                      valid
);
    localparam int SW = $clog2(NPORTS);
    logic [SW:0] pos;
    always_comb begin
        oh    = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            // scan from ptr upward, wrapping modulo NPORTS
            pos = {1'b0, ptr} + (SW+1)'(i);
            pos = pos >= (SW+1)'(NPORTS) ? pos - (SW+1)'(NPORTS) : pos;
            if (!valid && req[pos[SW-1:0]]) begin
                valid = 1'b1;
                idx   = pos[SW-1:0];
            end
        end
        oh[idx] = valid;
    end
endmodule

// File: rtl/sdr_16_port_arbiter.sv
// sdr_16_port_arbiter: round-robin SDRAM port arbiter with refresh credit scheduling
//   sdram_clk   - sole clock
//   sdram_rst_n - synchronous active-low reset
//   arb         - slave side of sdr_16_port_arbiter_if (requests, controller status, grants)
module sdr_16_port_arbiter
    import sdr_16_pkg::*;
#(
    parameter int NPORTS         = ARB_NPORTS,
    parameter int REFRESH_CYCLES = ARB_REFRESH_CYCLES,
    parameter int URGENT_LEVEL   = ARB_URGENT_LEVEL,
    parameter int MAX_PENDING    = ARB_MAX_PENDING
) (
    input logic                   sdram_clk,
    input logic                   sdram_rst_n,
    sdr_16_port_arbiter_if.slave  arb
);
    localparam int SW = $clog2(NPORTS);
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam int TW = $clog2(REFRESH_CYCLES);
    arb_state_t        state;
    logic [TW-1:0]     timer;
    logic [CW-1:0]     credits;
    logic [SW-1:0]     rr_ptr;
    logic [NPORTS-1:0] pick_oh;
    logic [SW-1:0]     pick_idx;
    logic              pick_valid;
    logic              add;
    logic              sub;
    logic              sat;
    sdr_16_rr_pick #(.NPORTS(NPORTS)) u_pick (
        .req   (arb.req),
        .ptr   (rr_ptr),
        .oh    (pick_oh),
        .idx   (pick_idx),
        .valid (pick_valid)
    );
    assign add      = timer == '0;
    // only refreshes we asked for consume credits; stray pulses during init are ignored
    assign sub      = arb.cmd_aref && state == ARB_RFR && credits != '0;
    assign sat      = credits == CW'(MAX_PENDING);
    assign arb.busy = state != ARB_IDLE;
    always_ff @(posedge sdram_clk) begin
        if (!sdram_rst_n) begin
            state                <= ARB_WAIT_INIT;
            arb.gnt              <= '0;
            arb.port_sel         <= '0;
            arb.refresh_req      <= 1'b0;
            arb.refresh_overflow <= 1'b0;
            credits              <= '0;
            rr_ptr               <= '0;
            timer                <= TW'(REFRESH_CYCLES - 1);
        end else begin
            timer   <= add ? TW'(REFRESH_CYCLES - 1) : timer - 1'b1;
            credits <= add && !sub ? (sat ? credits : credits + 1'b1) :
                       sub && !add ? credits - 1'b1 : credits;
            if (add && !sub && sat)
                arb.refresh_overflow <= 1'b1;
            case (state)
                ARB_WAIT_INIT: if (arb.state_idle) state <= ARB_IDLE;
                ARB_IDLE: begin
                    if (credits >= CW'(URGENT_LEVEL) || (credits != '0 && arb.req == '0)) begin
                        state           <= ARB_RFR;
                        arb.refresh_req <= 1'b1;
                    end else if (pick_valid) begin
                        state        <= ARB_GRANT;
                        arb.gnt      <= pick_oh;
                        arb.port_sel <= pick_idx;
                    end
                end
                ARB_GRANT: begin
                    // controller leaving idle commits the grant even if req drops that cycle
                    if (!arb.state_idle)
                        state <= ARB_BUSY;
                    else if (!arb.req[arb.port_sel]) begin
                        state   <= ARB_IDLE;
                        arb.gnt <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (arb.state_idle) begin
                        state   <= ARB_IDLE;
                        arb.gnt <= '0;
                        rr_ptr  <= arb.port_sel == SW'(NPORTS - 1) ? '0 : arb.port_sel + 1'b1;
                    end
                end
                ARB_RFR: begin
                    if (arb.cmd_aref)
                        arb.refresh_req <= 1'b0;
                    if (!arb.refresh_req && arb.state_idle)
                        state <= ARB_IDLE;
                end
                default: state <= ARB_WAIT_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_sdr_16_port_arbiter.sv
// tb_sdr_16_port_arbiter: directed self-checking bench for sdr_16_port_arbiter
module tb_sdr_16_port_arbiter;
    import sdr_16_pkg::*;
    logic sdram_clk = 1'b0;
    logic sdram_rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   mon = 1'b0;
    sdr_16_port_arbiter_if #(.NPORTS(4)) bus ();
    sdr_16_port_arbiter #(
        .NPORTS(4), .REFRESH_CYCLES(16), .URGENT_LEVEL(4), .MAX_PENDING(8)
    ) dut (
        .sdram_clk   (sdram_clk),
        .sdram_rst_n (sdram_rst_n),
        .arb         (bus)
    );
    always #5 sdram_clk = ~sdram_clk;
    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    always @(negedge sdram_clk)
        if (mon) begin
            check("no_overlap", int'(bus.gnt != '0 && bus.refresh_req), 0);
            check("onehot0", int'($onehot0(bus.gnt)), 1);
        end
    task automatic do_reset(input logic idle);
        sdram_rst_n    = 1'b0;
        bus.req        = '0;
        bus.cmd_aref   = 1'b0;
        bus.state_idle = idle;
        repeat (2) @(negedge sdram_clk);
        sdram_rst_n = 1'b1;
    endtask
    task automatic serve(output logic [3:0] g, output int ps);
        int n = 0;
        while (bus.gnt == '0 && n < 100) begin
            @(negedge sdram_clk);
            n++;
        end
        g  = bus.gnt;
        ps = int'(bus.port_sel);
        bus.state_idle = 1'b0;
        repeat (5) begin
            @(negedge sdram_clk);
            check("gnt_hold", int'(bus.gnt), int'(g));
        end
        bus.state_idle = 1'b1;
        @(negedge sdram_clk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        logic [3:0] g;
        int ps;
        int n;
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int exp_p [5] = '{0, 1, 2, 3, 0};
        // reset values and first refresh credit
        sdram_rst_n    = 1'b0;
        bus.req        = '0;
        bus.cmd_aref   = 1'b0;
        bus.state_idle = 1'b1;
        repeat (2) @(negedge sdram_clk);
        check("rst_gnt", int'(bus.gnt), 0);
        check("rst_sel", int'(bus.port_sel), 0);
        check("rst_rfr", int'(bus.refresh_req), 0);
        check("rst_ovf", int'(bus.refresh_overflow), 0);
        check("rst_busy", int'(bus.busy), 1);
        check("rst_cred", int'(dut.credits), 0);
        check("rst_state", int'(dut.state), int'(ARB_WAIT_INIT));
        sdram_rst_n = 1'b1;
        mon = 1'b1;
        n = 0;
        while (!bus.refresh_req && n < 40) begin
            @(negedge sdram_clk);
            n++;
        end
        check("rfr_latency", n, 17);
        bus.cmd_aref = 1'b1;
        @(negedge sdram_clk);
        bus.cmd_aref = 1'b0;
        check("aref_rfr_low", int'(bus.refresh_req), 0);
        check("aref_cred", int'(dut.credits), 0);
        @(negedge sdram_clk);
        check("rfr_to_idle", int'(bus.busy), 0);
        // round-robin rotation with all ports requesting
        do_reset(1'b1);
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve(g, ps);
            check($sformatf("rr_gnt%0d", i), int'(g), int'(exp_g[i]));
            check($sformatf("rr_sel%0d", i), ps, exp_p[i]);
        end
        // wrap-around from rr_ptr=2
        do_reset(1'b1);
        bus.req = 4'b0010;
        serve(g, ps);
        check("wrap_first", int'(g), 4'b0010);
        check("wrap_ptr", int'(dut.rr_ptr), 2);
        bus.req = 4'b0011;
        serve(g, ps);
        check("wrap_gnt", int'(g), 4'b0001);
        check("wrap_sel", ps, 0);
        // request withdrawn while still in GRANT
        do_reset(1'b1);
        bus.req = 4'b0100;
        n = 0;
        while (bus.gnt == '0 && n < 20) begin
            @(negedge sdram_clk);
            n++;
        end
        check("drop_gnt", int'(bus.gnt), 4'b0100);
        check("drop_sel", int'(bus.port_sel), 2);
        bus.req = '0;
        @(negedge sdram_clk);
        check("drop_cleared", int'(bus.gnt), 0);
        check("drop_idle", int'(bus.busy), 0);
        check("drop_ptr", int'(dut.rr_ptr), 0);
        // urgent refresh between grants
        do_reset(1'b1);
        bus.req = 4'b0001;
        n = 0;
        while (bus.gnt == '0 && n < 20) begin
            @(negedge sdram_clk);
            n++;
        end
        check("urg_gnt", int'(bus.gnt), 4'b0001);
        bus.state_idle = 1'b0;
        n = 0;
        while (dut.credits != 4'd4 && n < 100) begin
            @(negedge sdram_clk);
            n++;
        end
        check("urg_cred4", int'(dut.credits), 4);
        check("urg_hold", int'(bus.gnt), 4'b0001);
        bus.state_idle = 1'b1;
        @(negedge sdram_clk);
        check("urg_done", int'(bus.gnt), 0);
        check("urg_idle", int'(bus.busy), 0);
        @(negedge sdram_clk);
        check("urg_rfr", int'(bus.refresh_req), 1);
        check("urg_nognt", int'(bus.gnt), 0);
        bus.cmd_aref = 1'b1;
        @(negedge sdram_clk);
        bus.cmd_aref = 1'b0;
        check("urg_rfr_low", int'(bus.refresh_req), 0);
        check("urg_cred3", int'(dut.credits), 3);
        repeat (2) @(negedge sdram_clk);
        check("urg_regrant", int'(bus.gnt), 4'b0001);
        // credit saturation and sticky overflow
        do_reset(1'b0);
        repeat (143) @(negedge sdram_clk);
        check("sat_cred", int'(dut.credits), 8);
        check("sat_noovf", int'(bus.refresh_overflow), 0);
        @(negedge sdram_clk);
        check("ovf_cred", int'(dut.credits), 8);
        check("ovf_set", int'(bus.refresh_overflow), 1);
        bus.state_idle = 1'b1;
        repeat (2) @(negedge sdram_clk);
        check("ovf_rfr", int'(bus.refresh_req), 1);
        bus.cmd_aref = 1'b1;
        @(negedge sdram_clk);
        bus.cmd_aref = 1'b0;
        check("ovf_cred7", int'(dut.credits), 7);
        check("ovf_sticky", int'(bus.refresh_overflow), 1);
        do_reset(1'b1);
        check("ovf_cleared", int'(bus.refresh_overflow), 0);
        // reset during BUSY, then aref pulses in WAIT_INIT
        bus.req = 4'b0001;
        n = 0;
        while (bus.gnt == '0 && n < 20) begin
            @(negedge sdram_clk);
            n++;
        end
        bus.state_idle = 1'b0;
        repeat (2) @(negedge sdram_clk);
        check("mid_state", int'(dut.state), int'(ARB_BUSY));
        check("mid_gnt", int'(bus.gnt), 4'b0001);
        sdram_rst_n = 1'b0;
        @(negedge sdram_clk);
        check("mid_rst_gnt", int'(bus.gnt), 0);
        check("mid_rst_state", int'(dut.state), int'(ARB_WAIT_INIT));
        sdram_rst_n = 1'b1;
        bus.cmd_aref = 1'b1;
        @(negedge sdram_clk);
        bus.cmd_aref = 1'b0;
        @(negedge sdram_clk);
        check("init_aref_cred", int'(dut.credits), 0);
        check("init_stay", int'(dut.state), int'(ARB_WAIT_INIT));
        mon = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
